// File: rtl/ccg_seq_eval.sv
// ccg_seq_eval: elastic pipeline evaluating two boolean functions of x.
// Function A = (~x[5] & ~x[6]) | (x[3] ^ x[9]); function B = parity of x & MASK.
// Output bit f[k] takes B when OUT_SEL[k] is set, A otherwise.
// Stage 0 captures the evaluated vector; stages 1..DEPTH-1 are plain registers.
// Optional feature macro: CCG_SEQ_EVAL_STATS_EN adds a 16-bit saturating
// output-handshake counter on port res_cnt.
module ccg_seq_eval #(
  parameter int unsigned      N_IN    = 12,
  parameter int unsigned      N_OUT   = 15,
  parameter int unsigned      DEPTH   = 2,
  parameter logic [N_IN-1:0]  MASK    = '1,
  parameter logic [N_OUT-1:0] OUT_SEL = N_OUT'(15'h1780)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] f
`ifdef CCG_SEQ_EVAL_STATS_EN
  ,
  output logic [15:0]      res_cnt
`endif
);

  logic             fa;
  logic             fb;
  logic [N_OUT-1:0] fvec;

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] ld;
  logic [N_OUT-1:0] data [DEPTH];

  // Evaluate both functions on the incoming vector and steer per output bit
  always_comb begin
    fa   = (~x[5] & ~x[6]) | (x[3] ^ x[9]);
    fb   = ^(x & MASK);
    fvec = (OUT_SEL & {N_OUT{fb}}) | (~OUT_SEL & {N_OUT{fa}});
  end

  // Load enables: a stage may load when empty or when its content moves on.
  // Walked from the output backwards so each stage sees its successor's enable.
  always_comb begin
    logic        take;
    int unsigned idx;
    take = out_ready;
    ld   = '0;
    idx  = 0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      idx     = DEPTH - 1 - j;
      ld[idx] = ~vld[idx] | take;
      take    = ld[idx];
    end
  end

  assign in_ready  = ~rst & ld[0];
  assign out_valid = vld[DEPTH-1];
  assign f         = data[DEPTH-1];

  // Stage registers: stage 0 captures the evaluated vector, later stages shift
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data[i] <= '0;
      end
    end else begin
      if (ld[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          data[0] <= fvec;
        end
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (ld[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            data[i] <= data[i-1];
          end
        end
      end
    end
  end

`ifdef CCG_SEQ_EVAL_STATS_EN
  // Saturating count of output handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      res_cnt <= '0;
    end else if (out_valid && out_ready && (res_cnt != '1)) begin
      res_cnt <= res_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ccg_seq_eval.sv
// Self-checking bench for ccg_seq_eval with default parameters.
// Directed latency/backpressure/reset scenarios plus a randomized run,
// all scored against a queue-based reference of the boolean functions.
module tb_ccg_seq_eval;

  localparam int unsigned      N_IN    = 12;
  localparam int unsigned      N_OUT   = 15;
  localparam int unsigned      DEPTH   = 2;
  localparam logic [N_IN-1:0]  MASK_C  = '1;
  localparam logic [N_OUT-1:0] SEL_C   = 15'h1780;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  x;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] f;
`ifdef CCG_SEQ_EVAL_STATS_EN
  logic [15:0]      res_cnt;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [N_OUT-1:0] q [$];
  int unsigned      n_in  = 0;
  int unsigned      n_out = 0;
  logic             prev_stall = 1'b0;
  logic [N_OUT-1:0] prev_f = '0;

  ccg_seq_eval #(
    .N_IN    (N_IN),
    .N_OUT   (N_OUT),
    .DEPTH   (DEPTH),
    .MASK    (MASK_C),
    .OUT_SEL (SEL_C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f)
`ifdef CCG_SEQ_EVAL_STATS_EN
    ,
    .res_cnt   (res_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: evaluate the two functions straight from their definitions
  function automatic logic [N_OUT-1:0] ref_f(input logic [N_IN-1:0] v);
    logic a, b;
    logic [N_OUT-1:0] r;
    a = (!v[5] && !v[6]) || (v[3] != v[9]);
    b = 1'b0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (MASK_C[i] && v[i]) b = !b;
    end
    for (int k = 0; k < int'(N_OUT); k++) begin
      r[k] = SEL_C[k] ? b : a;
    end
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: handshakes seen at the negedge happen at the following posedge
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_f", f, prev_f);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out", 1'b1, 1'b0);
        else check("order_f", f, q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_f(x));
        n_in++;
      end
      prev_stall = out_valid && !out_ready;
      prev_f     = f;
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_IN-1:0] acc [8];
    int unsigned na;
    int unsigned in0, out0, cycles;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    cyc();
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_f", f, 15'h0000);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1'b1);

    // Single vector latency
    cyc();
    in_valid = 1'b1; x = 12'h000;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_1cyc", out_valid, 1'b0);
    cyc();
    @(negedge clk);
    check("lat_2cyc", out_valid, 1'b1);
    check("x000_f", f, 15'h687F);
    cyc();
    @(negedge clk);
    check("lat_empty", out_valid, 1'b0);

    // Back-to-back vectors
    cyc();
    in_valid = 1'b1; x = 12'h060;
    cyc();
    x = 12'h008;
    cyc();
    x = 12'h020;
    @(negedge clk);
    check("b2b_f0", f, 15'h0000);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_f1", f, 15'h7FFF);
    cyc();
    @(negedge clk);
    check("b2b_v2", out_valid, 1'b1);
    check("b2b_f2", f, 15'h1780);
    cyc();
    @(negedge clk);
    check("b2b_empty", out_valid, 1'b0);

    // Backpressure: pipeline fills to DEPTH then stalls
    cyc();
    out_ready = 1'b0; in_valid = 1'b1; x = 12'($urandom);
    na = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (in_ready && na < 8) begin acc[na] = x; na++; end
      cyc();
      x = 12'($urandom);
    end
    @(negedge clk);
    check("bp_accepted", na, DEPTH);
    check("bp_in_ready", in_ready, 1'b0);
    cyc();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1'b1);
    check("bp_out0", f, ref_f(acc[0]));
    cyc();
    @(negedge clk);
    check("bp_v1", out_valid, 1'b1);
    check("bp_out1", f, ref_f(acc[1]));
    cyc();
    @(negedge clk);
    check("bp_drained", out_valid, 1'b0);

    // Reset with two vectors in flight
    cyc();
    out_ready = 1'b0; in_valid = 1'b1; x = 12'h008;
    cyc();
    x = 12'h020;
    cyc();
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", in_ready, 1'b0);
    cyc();
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready1", in_ready, 1'b1);
    for (int c = 0; c < 4; c++) begin
      cyc();
      @(negedge clk);
      check("no_stale", out_valid, 1'b0);
    end

    // Randomized traffic
    cyc();
    in0 = n_in; out0 = n_out; cycles = 0;
    while ((n_in - in0) < 10000 && cycles < 60000) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      x         = 12'($urandom);
      @(negedge clk);
      if ((n_in - in0) >= 10000 && in_valid && in_ready) begin
        // this cycle's accept lands after the loop bound; stop offering it
      end
      cyc();
      cycles++;
      if ((n_in - in0) >= 10000) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) cyc();
    @(negedge clk);
    check("rand_accepted", n_in - in0, 10000);
    check("rand_count", n_out - out0, n_in - in0);
    check("rand_q_empty", q.size(), 0);

`ifdef CCG_SEQ_EVAL_STATS_EN
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("cnt_reset0", res_cnt, 16'h0000);
    cyc();
    out0 = n_out;
    in_valid = 1'b1; out_ready = 1'b1;
    cycles = 0;
    while ((n_out - out0) < 70000 && cycles < 80000) begin
      x = 12'($urandom);
      cyc();
      cycles++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("cnt_sat", res_cnt, 16'hFFFF);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("cnt_clear", res_cnt, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
